// File: rtl/soc_test_sequencer.sv
// Test sequencer for the RV32I SoC. It loads each test image, pulses core reset,
// then watches the core PC for the test's pass/fail address within a cycle budget.
module soc_test_sequencer #(
    parameter int XLEN       = 32,
    parameter int NUM_TESTS  = 3,
    parameter logic [NUM_TESTS*XLEN-1:0] PASS_ADDRS = {32'h2D68, 32'h2A7C, 32'h22CC},
    parameter logic [NUM_TESTS*XLEN-1:0] FAIL_ADDRS = {32'h2D64, 32'h2A78, 32'h22C8},
    parameter int MAX_CYCLES = 10000,
    parameter int RST_CYCLES = 2,
    parameter int PASS_HOLD  = 4,
    localparam int TW  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CW  = $clog2(MAX_CYCLES + 1),
    localparam int RCW = $clog2(RST_CYCLES + 1),
    localparam int PHW = $clog2(PASS_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            auto,
    input  logic [TW-1:0]   test_sel,
    input  logic            abort,
    input  logic [XLEN-1:0] pc,
    input  logic            load_ack,
    output logic            core_rst,
    output logic            load_req,
    output logic [TW-1:0]   cur_test,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [CW-1:0]   cycle_count,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HOLD    = 3'd2,
        S_RUN     = 3'd3,
        S_VERDICT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state, state_n;

    logic            auto_r;
    logic [RCW-1:0]  rst_cnt;
    logic [PHW-1:0]  match_cnt;
    logic            v_pass, v_fail, v_to;

    logic [XLEN-1:0] pass_addr, fail_addr;
    logic            start_ok, pc_pass, run_fail, run_pass, run_to, advance;
    logic [CW-1:0]   cc_next;

    // Image-load handshake: load_req is a level held for the whole LOAD state; the
    // load is complete on the first posedge that samples load_ack=1 while in LOAD.
    always_comb begin
        state_n   = state;
        pass_addr = PASS_ADDRS[int'(cur_test)*XLEN +: XLEN];
        fail_addr = FAIL_ADDRS[int'(cur_test)*XLEN +: XLEN];
        start_ok  = start && (state == S_IDLE || state == S_DONE) && (int'(test_sel) < NUM_TESTS);
        pc_pass   = (pc == pass_addr);
        run_fail  = (state == S_RUN) && (pc == fail_addr);
        run_pass  = (state == S_RUN) && !run_fail && pc_pass && (match_cnt == PHW'(PASS_HOLD - 1));
        cc_next   = (cycle_count >= CW'(MAX_CYCLES)) ? cycle_count : cycle_count + 1'b1;
        run_to    = (state == S_RUN) && !run_fail && !run_pass && (cc_next == CW'(MAX_CYCLES));
        advance   = v_pass && auto_r && (int'(cur_test) < NUM_TESTS - 1);

        case (state)
            S_IDLE, S_DONE: if (start_ok) state_n = S_LOAD;
            S_LOAD:         if (load_ack) state_n = S_HOLD;
            S_HOLD:         if (rst_cnt == RCW'(RST_CYCLES - 1)) state_n = S_RUN;
            S_RUN:          if (run_fail || run_pass || run_to) state_n = S_VERDICT;
            S_VERDICT:      state_n = advance ? S_LOAD : S_DONE;
            default:        state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            auto_r      <= 1'b0;
            cur_test    <= '0;
            rst_cnt     <= '0;
            match_cnt   <= '0;
            cycle_count <= '0;
            pass_mask   <= '0;
            v_pass      <= 1'b0;
            v_fail      <= 1'b0;
            v_to        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state <= state_n;
            if (abort) begin
                // pass_mask and cycle_count stay visible for post-mortem inspection
                v_pass  <= 1'b0;
                v_fail  <= 1'b0;
                v_to    <= 1'b0;
                pass    <= 1'b0;
                fail    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_ok) begin
                            auto_r    <= auto;
                            cur_test  <= test_sel;
                            pass_mask <= '0;
                            pass      <= 1'b0;
                            fail      <= 1'b0;
                            timeout   <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (load_ack) begin
                            rst_cnt     <= '0;
                            match_cnt   <= '0;
                            cycle_count <= '0;
                            v_pass      <= 1'b0;
                            v_fail      <= 1'b0;
                            v_to        <= 1'b0;
                        end
                    end
                    S_HOLD: rst_cnt <= rst_cnt + 1'b1;
                    S_RUN: begin
                        cycle_count <= cc_next;
                        match_cnt   <= pc_pass ? match_cnt + 1'b1 : '0;
                        v_pass      <= run_pass;
                        v_fail      <= run_fail || run_to;
                        v_to        <= run_to;
                    end
                    S_VERDICT: begin
                        if (v_pass) pass_mask[cur_test] <= 1'b1;
                        if (advance) begin
                            cur_test <= cur_test + 1'b1;
                        end else begin
                            pass    <= v_pass;
                            fail    <= v_fail;
                            timeout <= v_to;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The core is only released while a test is actually running.
    assign core_rst  = (state != S_RUN);
    assign load_req  = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN) || (state == S_VERDICT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule
